operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; reset asserts immediately and releases synchronously to clk.
REQ-002 Port list, clock and reset first:
- clk       input   1   system clock
- reset     input   1   asynchronous, active-low reset
- data_in   input   8   byte from board switches
- load_btn  input   1   asynchronous push-button, active-high
- clear     input   1   synchronous restart, active-high
- dataA     output  32  IEEE-754 single operand A
- dataB     output  32  IEEE-754 single operand B
- valid     output  1   both operands complete
- done      output  1   one-cycle pulse when valid rises
- step      output  3   index of the next byte to load, for the display
REQ-003 dataA and dataB SHALL connect directly to multiplierunit dataA/dataB with no added logic.

Function
REQ-004 load_btn SHALL pass through a 2-flip-flop synchronizer followed by a rising-edge detector.
- Exactly one capture occurs per press, however long the button is held.
REQ-005 A rising edge of load_btn sampled at clk edge k SHALL update the target byte register at clk edge k+2.
REQ-006 The FSM SHALL have three states: LOAD_A, LOAD_B and READY. A 2-bit counter byte_cnt tracks the byte position.
REQ-007 In LOAD_A, each captured edge SHALL write data_in to dataA[31-8*byte_cnt -: 8], so bytes load MSB first.
- byte_cnt then increments.
- On the 4th byte (byte_cnt=3), the state changes to LOAD_B and byte_cnt wraps to 0.
REQ-008 LOAD_B SHALL behave like LOAD_A but write dataB. On the 4th byte the state changes to READY.
REQ-009 In READY, edges SHALL be ignored. Operands, byte_cnt and state are held until clear.
REQ-010 valid SHALL be 1 exactly while state==READY. done SHALL be 1 only on the first cycle of READY.
REQ-011 step SHALL equal {state==LOAD_B, byte_cnt} in LOAD_A/LOAD_B, and 3'b111 in READY.
REQ-012 clear SHALL, on the next clk edge:
- set state to LOAD_A;
- set byte_cnt to 0;
- set dataA, dataB, valid and done to 0.
REQ-013 If clear and a captured edge coincide, clear SHALL win and the byte SHALL be discarded.
REQ-014 The edge-detector history SHALL keep updating during clear, so a held button does not produce a capture when clear deasserts.
REQ-015 Partial operands SHALL be visible on dataA/dataB while loading. Consumers qualify them with valid.

Reset
REQ-016 While reset is low, all of the following SHALL be 0:
- synchronizer and edge flip-flops;
- byte_cnt;
- dataA, dataB, valid, done.
State SHALL be LOAD_A and step SHALL be 3'b000.
REQ-017 Reset asserted mid-load SHALL discard all captured bytes. The first press after release writes dataA[31:24].
REQ-018 A press that straddles reset release SHALL NOT be captured unless the synchronized level is seen low then high after release.

Structure
REQ-019 A shared package operand_pkg SHALL hold:
- the state enum (LOAD_A, LOAD_B, READY);
- BYTES_PER_OPERAND=4;
- STEP_READY=3'b111.
REQ-020 Synchronizer plus edge detection SHALL be one sub-module, btn_edge (ports clk, reset, btn, pulse), reusable for other board buttons.
REQ-021 Target size is 120-250 lines of RTL including btn_edge.

Verification
REQ-022 Nominal load: bytes 40,FC,00,00 then 3E,40,00,00 (one press each) -> dataA=32'h40FC0000 and dataB=32'h3E400000.
- valid=1, done pulses one cycle, step=3'b111.
- Downstream multiplierunit gives dataR=32'h3FBD0000 (1.4765625).
REQ-023 Held button: load_btn high for 50 cycles with data_in=8'hC1 -> only dataA[31:24]=8'hC1 written, step=3'b001.
REQ-024 Press in READY with data_in=8'hFF -> dataA, dataB and step unchanged, no done pulse.
REQ-025 Clear coinciding with the capture of the 6th byte -> the byte is dropped.
- The next cycle shows state LOAD_A, step=0, dataA=dataB=0, valid=0.
REQ-026 Reset after 3 bytes of A (C1,90,00):
- During reset, all outputs are 0.
- After release, bytes 41,18,00,00,41,18,00,00 -> dataA=dataB=32'h41180000 and valid=1.
REQ-027 Latency check: load_btn rises just before edge k -> the byte register changes at edge k+2, not k+1 or k+3.

Source files
------------

// File: rtl/operand_pkg.sv
// Shared types and constants for the two-operand byte loader.
package operand_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    READY  = 2'd2
  } state_e;

  localparam int unsigned BYTES_PER_OPERAND = 4;
  localparam logic [2:0]  STEP_READY        = 3'b111;
  localparam logic [1:0]  LAST_BYTE         = 2'(BYTES_PER_OPERAND - 1);

  // Byte index 0 is the most significant byte, so operands load MSB first.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/operand_loader_btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous board button.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Pulse is valid during the cycle before prev_q catches up with sync2_q.
  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/operand_loader.sv
// Loads two 32-bit operands byte by byte from switches, one byte per button press.
module operand_loader
  import operand_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        load_btn,
  input  logic        clear,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic        valid,
  output logic        done,
  output logic [2:0]  step
);

  logic        capture;
  state_e      state_q,    state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] data_a_q,   data_a_d;
  logic [31:0] data_b_q,   data_b_d;
  logic        valid_q,    valid_d;
  logic        done_q,     done_d;

  btn_edge u_load_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (load_btn),
    .pulse (capture)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    if (clear) begin
      state_d    = LOAD_A;
      byte_cnt_d = '0;
      data_a_d   = '0;
      data_b_d   = '0;
      valid_d    = 1'b0;
    end else if (capture) begin
      case (state_q)
        LOAD_A: begin
          data_a_d   = put_byte(data_a_q, byte_cnt_q, data_in);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LAST_BYTE) state_d = LOAD_B;
        end
        LOAD_B: begin
          data_b_d   = put_byte(data_b_q, byte_cnt_q, data_in);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = READY;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD_A;
      byte_cnt_q <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign dataA = data_a_q;
  assign dataB = data_b_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign step  = (state_q == READY) ? STEP_READY : {state_q == LOAD_B, byte_cnt_q};

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: each press queues the expected register image.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        load_btn;
  logic        clear;
  logic [31:0] dataA, dataB;
  logic        valid, done;
  logic [2:0]  step;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  step;
    logic        valid;
    logic        done;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_a, m_b;
  int          m_state;
  int          m_cnt;
  logic        m_done;

  operand_loader dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load_btn (load_btn),
    .clear    (clear),
    .dataA    (dataA),
    .dataB    (dataB),
    .valid    (valid),
    .done     (done),
    .step     (step)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_step();
    if (m_state == 2) return 3'b111;
    return {m_state == 1, 2'(m_cnt)};
  endfunction

  task automatic model_clear();
    m_a = '0; m_b = '0; m_state = 0; m_cnt = 0; m_done = 1'b0;
  endtask

  task automatic model_capture(input logic [7:0] d);
    m_done = 1'b0;
    if (m_state == 0) begin
      m_a = m_a | ({24'h0, d} << (8 * (3 - m_cnt)));
    end else if (m_state == 1) begin
      m_b = m_b | ({24'h0, d} << (8 * (3 - m_cnt)));
    end
    if (m_state != 2) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 4) begin
        m_cnt = 0;
        m_state = m_state + 1;
        if (m_state == 2) m_done = 1'b1;
      end
    end
  endtask

  // Button rises just before edge k; result must appear at edge k+2, not k+1 or k+3.
  task automatic press(input logic [7:0] d, input int hold, input bit clr_at_capture);
    exp_t e;
    logic [31:0] pre_a, pre_b;
    logic [2:0]  pre_step;
    @(negedge clk);
    data_in  = d;
    load_btn = 1'b1;
    pre_a = m_a; pre_b = m_b; pre_step = m_step();
    if (clr_at_capture) model_clear(); else model_capture(d);
    sb.push_back('{a: m_a, b: m_b, step: m_step(), valid: (m_state == 2), done: m_done});
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (dataA !== pre_a || dataB !== pre_b || step !== pre_step) begin
      errors++;
      $display("FAIL early_update byte=%h: got A=%h B=%h step=%b want A=%h B=%h step=%b",
               d, dataA, dataB, step, pre_a, pre_b, pre_step);
    end
    if (clr_at_capture) begin
      @(negedge clk);
      clear = 1'b1;
    end
    @(posedge clk); #1;
    clear = 1'b0;
    e = sb.pop_front();
    checks++;
    if (dataA !== e.a) begin errors++; $display("FAIL capture_dataA byte=%h: got %h want %h", d, dataA, e.a); end
    checks++;
    if (dataB !== e.b) begin errors++; $display("FAIL capture_dataB byte=%h: got %h want %h", d, dataB, e.b); end
    checks++;
    if (step !== e.step) begin errors++; $display("FAIL capture_step byte=%h: got %b want %b", d, step, e.step); end
    checks++;
    if (valid !== e.valid) begin errors++; $display("FAIL capture_valid byte=%h: got %b want %b", d, valid, e.valid); end
    checks++;
    if (done !== e.done) begin errors++; $display("FAIL capture_done byte=%h: got %b want %b", d, done, e.done); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || dataA !== e.a || dataB !== e.b) begin
      errors++;
      $display("FAIL post_capture byte=%h: got done=%b A=%h B=%h want done=0 A=%h B=%h",
               d, done, dataA, dataB, e.a, e.b);
    end
    repeat (hold) @(negedge clk);
    load_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (dataA !== 32'h0 || dataB !== 32'h0 || valid !== 1'b0 || done !== 1'b0 || step !== 3'b000) begin
      errors++;
      $display("FAIL %s: got A=%h B=%h valid=%b done=%b step=%b want all zero",
               tag, dataA, dataB, valid, done, step);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; load_btn = 1'b0; data_in = '0;
    #3;
    check_all_zero("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(posedge clk); #1;
    check_all_zero("after_release");
  endtask

  task automatic test_nominal();
    logic [7:0] bytes [8] = '{8'h40, 8'hFC, 8'h00, 8'h00, 8'h3E, 8'h40, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) press(bytes[i], 1, 1'b0);
    checks++;
    if (dataA !== 32'h40FC0000 || dataB !== 32'h3E400000 || valid !== 1'b1 || step !== 3'b111) begin
      errors++;
      $display("FAIL nominal_final: got A=%h B=%h valid=%b step=%b want A=40fc0000 B=3e400000 valid=1 step=111",
               dataA, dataB, valid, step);
    end
  endtask

  task automatic test_ready_ignore();
    press(8'hFF, 2, 1'b0);
    checks++;
    if (dataA !== 32'h40FC0000 || dataB !== 32'h3E400000 || step !== 3'b111 || done !== 1'b0) begin
      errors++;
      $display("FAIL ready_ignore: got A=%h B=%h step=%b done=%b", dataA, dataB, step, done);
    end
  endtask

  task automatic test_held();
    do_clear();
    press(8'hC1, 46, 1'b0);
    checks++;
    if (dataA !== 32'hC1000000 || step !== 3'b001) begin
      errors++;
      $display("FAIL held_button: got A=%h step=%b want A=c1000000 step=001", dataA, step);
    end
  endtask

  task automatic test_clear_coincide();
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_clear();
    for (int i = 0; i < 5; i++) press(bytes[i], 1, 1'b0);
    // Button stays held across clear release; no capture may follow.
    press(8'h66, 10, 1'b1);
    checks++;
    if (dataA !== 32'h0 || dataB !== 32'h0 || valid !== 1'b0 || step !== 3'b000) begin
      errors++;
      $display("FAIL clear_coincide: got A=%h B=%h valid=%b step=%b want zeros", dataA, dataB, valid, step);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] pre [3] = '{8'hC1, 8'h90, 8'h00};
    logic [7:0] post [8] = '{8'h41, 8'h18, 8'h00, 8'h00, 8'h41, 8'h18, 8'h00, 8'h00};
    do_clear();
    for (int i = 0; i < 3; i++) press(pre[i], 1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("reset_midload_async");
    repeat (3) @(negedge clk);
    check_all_zero("reset_midload_held");
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) press(post[i], 1, 1'b0);
    checks++;
    if (dataA !== 32'h41180000 || dataB !== 32'h41180000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_reload: got A=%h B=%h valid=%b want 41180000 41180000 1", dataA, dataB, valid);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ready_ignore();
    test_held();
    test_clear_coincide();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
